// File: rtl/axi_llc_evict_wb.sv
// axi_llc_evict_wb -- LLC eviction write-back stage.
//
// Turns eviction descriptors plus the matching stream of evicted data beats
// into full-line AXI write bursts (AW/W/B). It keeps a small descriptor FIFO,
// counts bursts still awaiting B (outs_cnt) and bursts whose W data has not
// yet been fully accepted (w_pend), and keeps a sticky error flag for non-OKAY
// write responses.
//
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   desc_addr/valid/ready      eviction descriptor input (line address)
//   way_data/valid/ready       evicted data beats from the way switch
//   aw_*, w_*, b_*             AXI write channels towards memory
//   busy_o                     descriptor queued or burst in flight
//   err_o                      sticky, set by any non-OKAY B response
//
// Build option: AXI_LLC_EVICT_WB_SPILL_EN puts a two-entry skid register on
// the W path (registered w_valid/w_data/w_last, way_ready free of w_ready).
// Without it the W path is a combinational pass-through.
module axi_llc_evict_wb #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned BlockBeats     = 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned DescDepth      = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] desc_addr_i,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic [DataWidth-1:0] way_data_i,
  input  logic                 way_valid_i,
  output logic                 way_ready_o,
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic [7:0]           aw_len_o,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [DataWidth-1:0] w_data_o,
  output logic                 w_last_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  input  logic [1:0]           b_resp_i,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned OffW  = $clog2(BlockBeats * DataWidth / 8);
  localparam int unsigned PtrW  = (DescDepth > 1) ? $clog2(DescDepth) : 1;
  localparam int unsigned CntW  = $clog2(DescDepth + 1);
  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeatW = $clog2(BlockBeats);
  localparam logic [AddrWidth-1:0] LineMask = {AddrWidth{1'b1}} << OffW;

  // ---------------- descriptor FIFO ----------------
  logic [AddrWidth-1:0] fifo_q [DescDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      fill_q;
  logic                 fifo_empty, push, pop;

  assign fifo_empty   = (fill_q == '0);
  assign desc_ready_o = (fill_q != CntW'(DescDepth));
  assign push         = desc_valid_i & desc_ready_o;
  assign pop          = aw_valid_o & aw_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= desc_addr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(DescDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(DescDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      fill_q <= fill_q + CntW'(push) - CntW'(pop);
    end
  end

  // ---------------- AW / counters / B ----------------
  logic [OutW-1:0]  outs_q, pend_q;
  logic [BeatW-1:0] beat_q;
  logic             b_hs, beat_adv, last_adv, pend_nz, err_q;

  assign pend_nz    = (pend_q != '0);
  assign aw_valid_o = !fifo_empty && (outs_q < OutW'(MaxOutstanding))
                                  && (pend_q < OutW'(MaxOutstanding));
  assign aw_addr_o  = fifo_q[rd_ptr_q] & LineMask;
  assign aw_len_o   = 8'(BlockBeats - 1);
  assign b_ready_o  = (outs_q != '0);
  assign b_hs       = b_valid_i & b_ready_o;
  assign busy_o     = !fifo_empty || (outs_q != '0) || pend_nz;
  assign err_o      = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outs_q <= '0;
      pend_q <= '0;
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      // Increment and decrement in the same cycle cancel out.
      outs_q <= outs_q + OutW'(pop) - OutW'(b_hs);
      pend_q <= pend_q + OutW'(pop) - OutW'(last_adv);
      // BlockBeats is a power of two, so the natural wrap ends each line.
      if (beat_adv) beat_q <= beat_q + BeatW'(1);
      if (b_hs && b_resp_i != 2'b00) err_q <= 1'b1;
    end
  end

  // ---------------- W path ----------------
`ifdef AXI_LLC_EVICT_WB_SPILL_EN
  // Two-entry skid: input ready only looks at local state, so way_ready_o
  // is registered-only while one beat per cycle still flows.
  logic                 main_vld_q, skid_vld_q, main_last_q, skid_last_q;
  logic [DataWidth-1:0] main_data_q, skid_data_q;
  logic                 in_hs, in_last, out_hs;

  assign way_ready_o = pend_nz & !skid_vld_q;
  assign in_hs       = way_valid_i & way_ready_o;
  assign in_last     = (beat_q == BeatW'(BlockBeats - 1));
  assign out_hs      = main_vld_q & w_ready_i;
  assign beat_adv    = in_hs;
  assign last_adv    = in_hs & in_last;
  assign w_valid_o   = main_vld_q;
  assign w_data_o    = main_data_q;
  assign w_last_o    = main_last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      main_last_q <= 1'b0;
      skid_last_q <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else if (skid_vld_q) begin
      if (out_hs) begin
        main_data_q <= skid_data_q;
        main_last_q <= skid_last_q;
        skid_vld_q  <= 1'b0;
      end
    end else if (in_hs) begin
      main_vld_q <= 1'b1;
      if (!main_vld_q || out_hs) begin
        main_data_q <= way_data_i;
        main_last_q <= in_last;
      end else begin
        skid_vld_q  <= 1'b1;
        skid_data_q <= way_data_i;
        skid_last_q <= in_last;
      end
    end else if (out_hs) begin
      main_vld_q <= 1'b0;
    end
  end
`else
  // Beats only pass once their AW has been accepted (w_pend non-zero).
  assign w_valid_o   = way_valid_i & pend_nz;
  assign way_ready_o = w_ready_i & pend_nz;
  assign w_data_o    = way_data_i;
  assign w_last_o    = (beat_q == BeatW'(BlockBeats - 1));
  assign beat_adv    = w_valid_o & w_ready_i;
  assign last_adv    = beat_adv & w_last_o;
`endif

endmodule

// File: doc/axi_llc_evict_wb.md
Name: axi_llc_evict_wb

Overview:
Write-back stage directly downstream of the data-way switch. It consumes the per-beat read responses returned to the evict unit and the eviction descriptors produced by the evict unit. From these it issues full-line AXI write bursts (AW, W, B) towards the memory side. Every burst is one cache line of BlockBeats beats, and the block tracks outstanding write responses.

Parameters:
AddrWidth, 64, AXI address width.
DataWidth, 64, AXI data width; equals the data-way response data width.
BlockBeats, 8, beats per cache line; power of two, >= 2.
MaxOutstanding, 4, maximum number of AW bursts awaiting B; >= 1.
DescDepth, 2, depth of the eviction descriptor FIFO; >= 1.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous reset, active low.
desc_addr_i  in  AddrWidth  line address of the eviction; low log2(BlockBeats*DataWidth/8) bits are ignored.
desc_valid_i  in  1  descriptor valid.
desc_ready_o  out  1  descriptor FIFO not full.
way_data_i  in  DataWidth  evicted data beat from the way switch.
way_valid_i  in  1  data beat valid.
way_ready_o  out  1  data beat accepted.
aw_addr_o  out  AddrWidth  burst address, line-aligned.
aw_len_o  out  8  burst length, fixed at BlockBeats-1.
aw_valid_o  out  1  AW valid.
aw_ready_i  in  1  AW ready.
w_data_o  out  DataWidth  write data.
w_last_o  out  1  last beat of the burst.
w_valid_o  out  1  W valid.
w_ready_i  in  1  W ready.
b_resp_i  in  2  AXI write response.
b_valid_i  in  1  B valid.
b_ready_o  out  1  B ready.
busy_o  out  1  any work pending.
err_o  out  1  sticky error flag.

Behaviour:
- Reset:
  - All FIFOs are empty; outstanding count, pending-W count and beat counter are 0.
  - All valid outputs, err_o and busy_o are 0; desc_ready_o is 1.
  - Reset may assert mid-burst; all state is discarded and no partial burst resumes.
- Descriptor FIFO: depth DescDepth, non-fall-through.
  - desc_ready_o = !full.
  - An accepted descriptor becomes visible on AW one cycle after the push at the earliest.
- AW channel:
  - aw_valid_o = FIFO not empty AND outs_cnt < MaxOutstanding AND w_pend < MaxOutstanding.
  - aw_addr_o = head address with the offset bits forced to 0.
  - aw_valid_o stays stable until the handshake; the FIFO pops on the handshake.
- Counters (saturating at MaxOutstanding by construction):
  - outs_cnt: +1 on AW handshake, -1 on B handshake; both in the same cycle leaves it unchanged.
  - w_pend: +1 on AW handshake, -1 on the W handshake carrying w_last_o; both in the same cycle leaves it unchanged.
- W channel:
  - No W beat is sent before its AW is accepted.
  - Beats are passed through only while w_pend > 0.
  - w_valid_o = way_valid_i & (w_pend != 0); way_ready_o = w_ready_i & (w_pend != 0).
  - beat_cnt increments on each W handshake and wraps to 0 after BlockBeats-1.
  - w_last_o = (beat_cnt == BlockBeats-1).
- B channel:
  - b_ready_o = (outs_cnt != 0).
  - A B handshake with b_resp_i != 2'b00 sets err_o; err_o is cleared only by reset.
  - A B handshake while outs_cnt == 0 is impossible by construction; the bench asserts against it.
- busy_o = desc FIFO not empty OR outs_cnt != 0 OR w_pend != 0.
- Latency:
  - Descriptor to aw_valid_o: 1 cycle minimum.
  - way_valid_i to w_valid_o: 0 cycles, combinational, when the optional feature is absent.

Optional Feature:
- Macro: AXI_LLC_EVICT_WB_SPILL_EN.
- Defined: a spill register sits on the W path (data and last).
  - w_valid_o, w_data_o and w_last_o are registered, adding 1 cycle of latency.
  - way_ready_o no longer depends combinationally on w_ready_i.
  - Full throughput is kept: 1 beat per cycle.
  - beat_cnt and the w_pend decrement then count the spill-register input handshake.
- Undefined: combinational pass-through as described in Behaviour.

Test Plan:
1. Reset, then one descriptor at addr 0x1234_5678 with 8 beats 0..7, all readies held at 1 -> AW addr 0x1234_5640 len 7; 8 W beats with w_last_o only on beat 7; after B OKAY, busy_o=0 and err_o=0.
2. Way beats presented before the AW handshake, aw_ready_i=0 for 5 cycles -> w_valid_o=0 and way_ready_o=0 until AW is accepted, then data flows.
3. Six descriptors, b_valid_i held at 0 -> exactly 4 AWs issued; desc_ready_o=0 once the FIFO holds 2; releasing one B lets the 5th AW issue the next cycle.
4. B handshake and AW handshake in the same cycle with outs_cnt=2 -> outs_cnt stays 2.
5. B with b_resp_i=2'b10 -> err_o=1 and stays 1 through later OKAY responses until rst_ni=0.
6. Reset asserted after beat 3 of a burst -> all outputs 0 immediately; a new descriptor afterwards starts again at beat_cnt=0.
